// File: rtl/clk_meas_pkg.sv
// Shared definitions for the divided-clock meter: FSM encoding and default sizing.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int          DEF_CNT_W       = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 32'h0000_FFFF;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, followed by a history flop
// that turns the synchronised level into single-cycle rise/fall pulses.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sig_in,
    output logic rise_det,
    output logic fall_det
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    // Shift the raw input through the synchroniser chain and keep last level.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], sig_in};
        hist_d = sync_q[STAGES-1];
    end

    // Synchroniser and history registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise_det =  sync_q[STAGES-1] & ~hist_q;
    assign fall_det = ~sync_q[STAGES-1] &  hist_q;

endmodule

// File: rtl/clk_div_meter.sv
// Measures period and high time of a slow clock in fast-clock cycles.
// One-shot on start, or back-to-back (every other period) while cont is high.
module clk_div_meter
    import clk_meas_pkg::*;
#(
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT_CYC - 1);

    logic rise_det, fall_det;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             seen_fall_q, seen_fall_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             timeout_q, timeout_d;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in   (clk_in),
        .reset    (reset),
        .sig_in   (sig_in),
        .rise_det (rise_det),
        .fall_det (fall_det)
    );

    // Next-state and counter/result update for the measurement FSM.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        pcnt_d      = pcnt_q;
        hcnt_d      = hcnt_q;
        seen_fall_d = seen_fall_q;
        period_d    = period_q;
        high_d      = high_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    timeout_d = 1'b0;
                end
                if (start || cont) begin
                    state_d = WAIT_RISE;
                    tcnt_d  = '0;
                end
            end

            WAIT_RISE: begin
                if (rise_det) begin
                    state_d     = MEASURE;
                    pcnt_d      = ONE;
                    hcnt_d      = '0;
                    seen_fall_d = 1'b0;
                end else if (tcnt_q == TO_M1) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + ONE;
                end
            end

            MEASURE: begin
                if (rise_det) begin
                    state_d  = DONE;
                    period_d = pcnt_q;
                    high_d   = seen_fall_q ? hcnt_q : '0;
                end else if (pcnt_q >= TO_LIM) begin
                    // Abort keeps the previous results visible.
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    if (pcnt_q != '1) begin
                        pcnt_d = pcnt_q + ONE;
                    end
                    if (fall_det && !seen_fall_q) begin
                        hcnt_d      = pcnt_q;
                        seen_fall_d = 1'b1;
                    end
                end
            end

            DONE: begin
                // The rise that closed MEASURE is consumed; wait for the next one.
                state_d = cont ? WAIT_RISE : IDLE;
                tcnt_d  = '0;
            end

            default: state_d = IDLE;
        endcase
    end

    // State, counter and result registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            pcnt_q      <= '0;
            hcnt_q      <= '0;
            seen_fall_q <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            pcnt_q      <= pcnt_d;
            hcnt_q      <= hcnt_d;
            seen_fall_q <= seen_fall_d;
            period_q    <= period_d;
            high_q      <= high_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign timeout   = timeout_q;
    assign valid     = (state_q == DONE);
    assign busy      = (state_q == WAIT_RISE) || (state_q == MEASURE);

endmodule
